// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch unit: redirect select codes, reset vector
// and the instruction word that decode substitutes for a squashed slot.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    PCSEL_PLUS4 = 2'b00,
    PCSEL_JAL   = 2'b01,
    PCSEL_BR    = 2'b10,
    PCSEL_RSVD  = 2'b11
  } pcsel_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;

  // addi x0, x0, 0 -- decode issues this whenever id_valid is low
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle between the ID/EX redirect logic (master) and the fetch unit
// (slave): hold/redirect requests in, fetch address and IF/ID state out.
interface pc_fetch_unit_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);

  logic              stall;
  logic [1:0]        PCSel;
  logic [PC_W-1:0]   jal_target;
  logic [PC_W-1:0]   alu_target;

  logic [PC_W-1:0]   imem_addr;
  logic [PC_W-1:0]   pc_if;
  logic              if_valid;
  logic [PC_W-1:0]   pc_id;
  logic              id_valid;
  logic              misaligned_target;
  logic [CNT_W-1:0]  redirect_count;

  modport master (
    output stall, PCSel, jal_target, alu_target,
    input  imem_addr, pc_if, if_valid, pc_id, id_valid,
           misaligned_target, redirect_count
  );

  modport slave (
    input  stall, PCSel, jal_target, alu_target,
    output imem_addr, pc_if, if_valid, pc_id, id_valid,
           misaligned_target, redirect_count
  );

endinterface

// File: rtl/pc_fetch_unit_pc_next_mux.sv
// Next-fetch address select. An EX branch outranks the ID stall because
// the stalled ID word is itself on the wrong path once EX redirects.
module pc_fetch_unit_pc_next_mux
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [1:0]      pcsel,
  input  logic            stall,
  input  logic [PC_W-1:0] pc_if,
  input  logic [PC_W-1:0] jal_target,
  input  logic [PC_W-1:0] alu_target,
  output logic [PC_W-1:0] next_pc,
  output logic            misaligned,
  output logic            jal_taken,
  output logic            br_taken
);

  logic [PC_W-1:0] jal_aligned;
  logic [PC_W-1:0] alu_aligned;

  assign jal_aligned = {jal_target[PC_W-1:2], 2'b00};
  assign alu_aligned = {alu_target[PC_W-1:2], 2'b00};

  always_comb begin
    next_pc    = pc_if + PC_W'(4);
    misaligned = 1'b0;
    jal_taken  = 1'b0;
    br_taken   = 1'b0;
    if (pcsel == PCSEL_BR) begin
      next_pc    = alu_aligned;
      misaligned = |alu_target[1:0];
      br_taken   = 1'b1;
    end else if (stall) begin
      next_pc = pc_if;
    end else if (pcsel == PCSEL_JAL) begin
      next_pc    = jal_aligned;
      misaligned = |jal_target[1:0];
      jal_taken  = 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC owner for the 3-stage pipeline: drives the synchronous IMEM one
// cycle ahead and tracks IF/ID valid bits so wrong-path words become bubbles.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
  parameter int              CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rst,
  pc_fetch_unit_if.slave bus
);

  logic [PC_W-1:0]  next_pc;
  logic             mis_strobe;
  logic             jal_taken;
  logic             br_taken;

  logic [PC_W-1:0]  pc_if_q;
  logic             if_valid_q;
  logic [PC_W-1:0]  pc_id_q;
  logic             id_valid_q;
  logic             misaligned_q;
  logic [CNT_W-1:0] redirect_count_q;

  pc_fetch_unit_pc_next_mux #(
    .PC_W (PC_W)
  ) u_next_mux (
    .pcsel      (bus.PCSel),
    .stall      (bus.stall),
    .pc_if      (pc_if_q),
    .jal_target (bus.jal_target),
    .alu_target (bus.alu_target),
    .next_pc    (next_pc),
    .misaligned (mis_strobe),
    .jal_taken  (jal_taken),
    .br_taken   (br_taken)
  );

  // pc_if resets one word early so the first fetch after reset is RESET_PC
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_if_q          <= RESET_PC - PC_W'(4);
      if_valid_q       <= 1'b0;
      pc_id_q          <= '0;
      id_valid_q       <= 1'b0;
      misaligned_q     <= 1'b0;
      redirect_count_q <= '0;
    end else begin
      pc_if_q    <= next_pc;
      if_valid_q <= 1'b1;
      if (br_taken || !bus.stall) begin
        pc_id_q    <= pc_if_q;
        id_valid_q <= (br_taken || jal_taken) ? 1'b0 : if_valid_q;
      end
      if (mis_strobe) begin
        misaligned_q <= 1'b1;
      end
      if (br_taken || jal_taken) begin
        redirect_count_q <= redirect_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.imem_addr         = next_pc;
  assign bus.pc_if             = pc_if_q;
  assign bus.if_valid          = if_valid_q;
  assign bus.pc_id             = pc_id_q;
  assign bus.id_valid          = id_valid_q;
  assign bus.misaligned_target = misaligned_q;
  assign bus.redirect_count    = redirect_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed walk through the fetch unit scenarios followed by random traffic,
// all compared against a slot-level model of the IF and ID stages.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_unit_if #(.PC_W(32), .CNT_W(32)) bus ();

  pc_fetch_unit #(
    .PC_W     (32),
    .RESET_PC (RST_PC),
    .CNT_W    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // model: the word sitting in IF and in ID, plus the two status items
  logic [31:0] m_if_pc, m_id_pc, m_cnt;
  logic        m_if_ok, m_id_ok, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_if_pc = RST_PC - 32'd4;
    m_if_ok = 1'b0;
    m_id_pc = 32'd0;
    m_id_ok = 1'b0;
    m_mis   = 1'b0;
    m_cnt   = 32'd0;
  endtask

  // One cycle: apply inputs, check the fetch address, clock, check state.
  task automatic step(input logic r, input logic s, input logic [1:0] sel,
                      input logic [31:0] jt, input logic [31:0] at);
    logic [31:0] fetch;
    logic        take_br, take_jal;
    rst            = r;
    bus.stall      = s;
    bus.PCSel      = sel;
    bus.jal_target = jt;
    bus.alu_target = at;
    take_br  = (sel == 2'b10);
    take_jal = (sel == 2'b01) && !s;
    if (take_br)       fetch = at & ~32'd3;
    else if (s)        fetch = m_if_pc;
    else if (take_jal) fetch = jt & ~32'd3;
    else               fetch = m_if_pc + 32'd4;
    #1;
    if (!r) chk("imem_addr", bus.imem_addr, fetch);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      // a redirect kills whatever would have moved into ID; a stall without
      // an EX branch leaves both IF and ID where they are
      if (take_br || !s) begin
        m_id_pc = m_if_pc;
        m_id_ok = m_if_ok && !(take_br || take_jal);
      end
      m_if_pc = fetch;
      m_if_ok = 1'b1;
      if (take_br  && at[1:0] != 2'b00) m_mis = 1'b1;
      if (take_jal && jt[1:0] != 2'b00) m_mis = 1'b1;
      if (take_br || take_jal) m_cnt = m_cnt + 32'd1;
    end
    @(negedge clk);
    chk("pc_if",          bus.pc_if,                     m_if_pc);
    chk("if_valid",       {31'd0, bus.if_valid},          {31'd0, m_if_ok});
    chk("pc_id",          bus.pc_id,                     m_id_pc);
    chk("id_valid",       {31'd0, bus.id_valid},          {31'd0, m_id_ok});
    chk("misaligned",     {31'd0, bus.misaligned_target}, {31'd0, m_mis});
    chk("redirect_count", bus.redirect_count,            m_cnt);
  endtask

  initial begin
    logic        r, s;
    logic [1:0]  sel;
    model_reset();

    // reset release
    step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
    step(1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
    chk("rst_pc_if", bus.pc_if, 32'h3FFF_FFFC);
    step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    chk("first_pc_if", bus.pc_if, 32'h4000_0000);
    chk("first_if_valid", {31'd0, bus.if_valid}, 32'd1);
    step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    chk("first_id_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("first_pc_id", bus.pc_id, 32'h4000_0000);
    repeat (3) step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    chk("pre_jal_pc_if", bus.pc_if, 32'h4000_0010);

    // JAL redirect
    step(1'b0, 1'b0, 2'b01, 32'h4000_0100, 32'd0);
    chk("jal_pc_if", bus.pc_if, 32'h4000_0100);
    chk("jal_id_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("jal_count", bus.redirect_count, 32'd1);

    // branch overrides stall
    step(1'b0, 1'b1, 2'b10, 32'd0, 32'h4000_0200);
    chk("br_pc_if", bus.pc_if, 32'h4000_0200);
    chk("br_id_valid", {31'd0, bus.id_valid}, 32'd0);

    // JAL held by a stall, taken once on release
    repeat (3) begin
      step(1'b0, 1'b1, 2'b01, 32'h4000_0400, 32'd0);
      chk("stall_pc_if", bus.pc_if, 32'h4000_0200);
      chk("stall_count", bus.redirect_count, 32'd2);
    end
    step(1'b0, 1'b0, 2'b01, 32'h4000_0400, 32'd0);
    chk("release_count", bus.redirect_count, 32'd3);
    step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);

    // wrap then misaligned branch target
    step(1'b0, 1'b0, 2'b01, 32'hFFFF_FFFC, 32'd0);
    step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    chk("wrap_pc_if", bus.pc_if, 32'h0000_0000);
    step(1'b0, 1'b0, 2'b10, 32'd0, 32'h4000_0302);
    chk("mis_pc_if", bus.pc_if, 32'h4000_0300);
    chk("mis_flag", {31'd0, bus.misaligned_target}, 32'd1);
    repeat (2) step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    chk("mis_sticky", {31'd0, bus.misaligned_target}, 32'd1);

    // reset during a branch
    step(1'b1, 1'b0, 2'b10, 32'd0, 32'h4000_0500);
    chk("midrst_count", bus.redirect_count, 32'd0);
    chk("midrst_mis", {31'd0, bus.misaligned_target}, 32'd0);
    step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    chk("midrst_pc_if", bus.pc_if, 32'h4000_0000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 59) == 0);
      s   = ($urandom_range(0, 3) == 0);
      sel = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      step(r, s, sel, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
